// File: rtl/psk_symbol_modulator.sv
// M-ary PSK modulator: a phase-continuous NCO carrier rotated by a per-symbol phase
// offset, with a one-entry symbol holding register and I/Q outputs from a full-wave sine ROM.
module psk_symbol_modulator #(
  parameter int SYM_BITS   = 3,
  parameter int ACC_W      = 16,
  parameter int LUT_ADDR_W = 8,
  parameter int OUT_W      = 8,
  parameter int SPS        = 64,
  parameter int GRAY_EN    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ACC_W-1:0]        ftw,
  input  logic [SYM_BITS-1:0]     sym_data,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  output logic signed [OUT_W-1:0] wave_i,
  output logic signed [OUT_W-1:0] wave_q,
  output logic                    sym_start,
  output logic                    busy,
  output logic                    underrun
);

  // Handshake: a symbol is transferred on every rising edge where sym_valid and
  // sym_ready are both 1; sym_ready depends only on internal state, never on sym_valid.

  localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
  localparam int CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam logic [ACC_W-1:0] QUARTER  = {2'b01, {(ACC_W-2){1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Elaboration-time sine: fold into the first quadrant so the zero crossings and peaks are exact.
  function automatic int sin_entry(input int k);
    int  kk;
    int  amp;
    bit  neg;
    real x;
    real term;
    real sum;
    kk  = k % LUT_DEPTH;
    amp = (1 << (OUT_W - 1)) - 1;
    neg = 1'b0;
    if (kk >= LUT_DEPTH / 2) begin
      neg = 1'b1;
      kk  = kk - LUT_DEPTH / 2;
    end
    if (kk > LUT_DEPTH / 4) kk = LUT_DEPTH / 2 - kk;
    x    = 2.0 * 3.14159265358979323846 * real'(kk) / real'(LUT_DEPTH);
    term = x;
    sum  = x;
    for (int j = 1; j < 12; j++) begin
      term = -term * x * x / real'((2 * j) * (2 * j + 1));
      sum  = sum + term;
    end
    kk = int'(real'(amp) * sum);
    return neg ? -kk : kk;
  endfunction

  function automatic logic [SYM_BITS-1:0] map_sym(input logic [SYM_BITS-1:0] s);
    return (GRAY_EN != 0) ? (s ^ (s >> 1)) : s;
  endfunction

  logic signed [OUT_W-1:0] w_lut [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    assign w_lut[k] = OUT_W'(sin_entry(k));
  end

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_hold_full;
  logic [SYM_BITS-1:0]     r_hold_sym;
  logic [SYM_BITS-1:0]     r_active;
  logic [CNT_W-1:0]        r_cnt;
  logic [ACC_W-1:0]        r_acc;
  logic [LUT_ADDR_W-1:0]   r_addr_q;
  logic [LUT_ADDR_W-1:0]   r_addr_i;
  logic                    r_s1_valid;
  logic signed [OUT_W-1:0] r_wave_i;
  logic signed [OUT_W-1:0] r_wave_q;
  logic                    r_sym_start;
  logic                    r_underrun;

  logic                    w_take;
  logic                    w_pop;
  logic                    w_underrun_set;
  logic                    w_cnt_last;
  logic                    w_run;
  logic [ACC_W-1:0]        w_offset;
  logic [ACC_W-1:0]        w_sum_q;
  logic [ACC_W-1:0]        w_sum_i;

  assign w_take     = sym_valid && !r_hold_full;
  assign w_cnt_last = (r_cnt == CNT_LAST);
  assign w_run      = (r_state == RUN);
  assign w_offset   = ACC_W'(r_active) << (ACC_W - SYM_BITS);
  assign w_sum_q    = r_acc + w_offset;
  assign w_sum_i    = w_sum_q + QUARTER;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_underrun_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_pop       = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_cnt_last) begin
          if (r_hold_full) begin
            w_pop = 1'b1;
          end else begin
            w_underrun_set = 1'b1;
            w_state_nxt    = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold_sym  <= '0;
      r_active    <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_addr_q    <= '0;
      r_addr_i    <= '0;
      r_s1_valid  <= 1'b0;
      r_wave_i    <= '0;
      r_wave_q    <= '0;
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_take) begin
        r_hold_full <= 1'b1;
        r_hold_sym  <= sym_data;
      end else if (w_pop) begin
        r_hold_full <= 1'b0;
      end

      if (w_pop)               r_active <= map_sym(r_hold_sym);
      else if (w_underrun_set) r_active <= '0;

      r_cnt <= (w_run && !w_cnt_last) ? r_cnt + CNT_W'(1) : '0;
      // The carrier phase runs on across symbol boundaries and only restarts from IDLE.
      r_acc <= (w_run && !w_underrun_set) ? r_acc + ftw : '0;

      r_addr_q   <= w_run ? w_sum_q[ACC_W-1 -: LUT_ADDR_W] : '0;
      r_addr_i   <= w_run ? w_sum_i[ACC_W-1 -: LUT_ADDR_W] : '0;
      r_s1_valid <= w_run;
      r_wave_q   <= r_s1_valid ? w_lut[r_addr_q] : '0;
      r_wave_i   <= r_s1_valid ? w_lut[r_addr_i] : '0;

      r_sym_start <= w_pop;
      r_underrun  <= r_underrun || w_underrun_set;
    end
  end

  assign sym_ready = !r_hold_full;
  assign busy      = w_run;
  assign sym_start = r_sym_start;
  assign underrun  = r_underrun;
  assign wave_i    = r_wave_i;
  assign wave_q    = r_wave_q;

endmodule

// File: tb/tb_psk_symbol_modulator.sv
// Directed bench for psk_symbol_modulator: two instances (binary and Gray mapping) share
// stimulus; expected samples are hand-computed for ftw=16'h2000 and SPS=8 (45 degrees/cycle).
module tb_psk_symbol_modulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ftw;
  logic [2:0]  sym_data;
  logic        sym_valid;

  logic              d0_sym_ready, d0_sym_start, d0_busy, d0_underrun;
  logic signed [7:0] d0_wave_i, d0_wave_q;
  logic              d1_sym_ready, d1_sym_start, d1_busy, d1_underrun;
  logic signed [7:0] d1_wave_i, d1_wave_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Samples of 127*sin and 127*cos at 45-degree steps.
  localparam int Q_TAB[8] = '{0, 90, 127, 90, 0, -90, -127, -90};
  localparam int I_TAB[8] = '{127, 90, 0, -90, -127, -90, 0, 90};

  always #5 clk = ~clk;

  psk_symbol_modulator #(
    .SYM_BITS(3), .ACC_W(16), .LUT_ADDR_W(8), .OUT_W(8), .SPS(8), .GRAY_EN(0)
  ) dut0 (
    .clk(clk), .rst(rst), .ftw(ftw), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(d0_sym_ready), .wave_i(d0_wave_i), .wave_q(d0_wave_q),
    .sym_start(d0_sym_start), .busy(d0_busy), .underrun(d0_underrun)
  );

  psk_symbol_modulator #(
    .SYM_BITS(3), .ACC_W(16), .LUT_ADDR_W(8), .OUT_W(8), .SPS(8), .GRAY_EN(1)
  ) dut1 (
    .clk(clk), .rst(rst), .ftw(ftw), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_ready(d1_sym_ready), .wave_i(d1_wave_i), .wave_q(d1_wave_q),
    .sym_start(d1_sym_start), .busy(d1_busy), .underrun(d1_underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    sym_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int transfers;
    int starts;
    int n;
    int idx;

    rst       = 1'b1;
    ftw       = 16'h2000;
    sym_data  = 3'd0;
    sym_valid = 1'b0;
    step();
    step();

    // Reset state
    check("rst_wave_i", d0_wave_i, 0);
    check("rst_wave_q", d0_wave_q, 0);
    check("rst_ready", d0_sym_ready, 1);
    check("rst_busy", d0_busy, 0);
    check("rst_start", d0_sym_start, 0);
    check("rst_underrun", d0_underrun, 0);
    check("rst_d1_ready", d1_sym_ready, 1);

    // Single symbol 0, then underrun
    rst       = 1'b0;
    sym_data  = 3'd0;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    check("single_hold_ready", d0_sym_ready, 0);
    check("single_hold_busy", d0_busy, 0);
    step();
    check("single_start", d0_sym_start, 1);
    check("single_busy", d0_busy, 1);
    check("single_ready_after_pop", d0_sym_ready, 1);
    step();
    check("single_start_pulse", d0_sym_start, 0);
    check("single_lat_wave_i", d0_wave_i, 0);
    check("single_lat_wave_q", d0_wave_q, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("single_wave_q[%0d]", k), d0_wave_q, Q_TAB[k]);
      check($sformatf("single_wave_i[%0d]", k), d0_wave_i, I_TAB[k]);
      if (k == 5) begin
        check("single_busy_last", d0_busy, 1);
        check("single_no_underrun", d0_underrun, 0);
      end
      if (k == 6) begin
        check("single_underrun", d0_underrun, 1);
        check("single_idle", d0_busy, 0);
      end
    end
    step();
    check("single_tail_wave_i", d0_wave_i, 0);
    check("single_tail_wave_q", d0_wave_q, 0);
    check("single_underrun_sticky", d0_underrun, 1);

    // Back-to-back symbols 0 then 4
    do_reset();
    check("b2b_underrun_cleared", d0_underrun, 0);
    sym_data  = 3'd0;
    sym_valid = 1'b1;
    step();
    sym_data = 3'd4;
    step();
    check("b2b_start0", d0_sym_start, 1);
    step();
    sym_valid = 1'b0;
    check("b2b_hold_full", d0_sym_ready, 0);
    for (int c = 1; c <= 17; c++) begin
      check($sformatf("b2b_start[%0d]", c), d0_sym_start, (c == 8) ? 1 : 0);
      check($sformatf("b2b_underrun[%0d]", c), d0_underrun, (c >= 16) ? 1 : 0);
      if (c <= 15) check($sformatf("b2b_busy[%0d]", c), d0_busy, 1);
      if (c >= 2) begin
        n   = c - 2;
        idx = (n < 8) ? n : (n + 4) % 8;
        check($sformatf("b2b_wave_q[%0d]", n), d0_wave_q, Q_TAB[idx]);
        check($sformatf("b2b_wave_i[%0d]", n), d0_wave_i, I_TAB[idx]);
      end
      step();
    end

    // Symbol 3: Gray maps to 2 (90 deg), binary stays 3 (135 deg)
    do_reset();
    sym_data  = 3'd3;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    step();
    check("gray_start", d1_sym_start, 1);
    step();
    step();
    check("gray_wave_q", d1_wave_q, 127);
    check("gray_wave_i", d1_wave_i, 0);
    check("bin3_wave_q", d0_wave_q, 90);
    check("bin3_wave_i", d0_wave_i, -90);

    // Continuous offer: one transfer per symbol, no underrun
    do_reset();
    sym_valid = 1'b1;
    transfers = 0;
    starts    = 0;
    for (int c = 0; c <= 38; c++) begin
      sym_data = 3'(c);
      check($sformatf("stream_ready[%0d]", c), d0_sym_ready,
            ((c == 0) || (c >= 2 && (c - 2) % 8 == 0)) ? 1 : 0);
      if (d0_sym_ready && sym_valid) transfers++;
      if (d0_sym_start) starts++;
      if (c < 38) step();
    end
    check("stream_transfers", transfers, 6);
    check("stream_starts", starts, 5);
    check("stream_underrun", d0_underrun, 0);
    check("stream_busy", d0_busy, 1);

    // Reset mid-symbol (counter=4, hold full) with sym_valid still high
    rst = 1'b1;
    step();
    check("midrst_wave_i", d0_wave_i, 0);
    check("midrst_wave_q", d0_wave_q, 0);
    check("midrst_ready", d0_sym_ready, 1);
    check("midrst_busy", d0_busy, 0);
    check("midrst_underrun", d0_underrun, 0);
    check("midrst_start", d0_sym_start, 0);
    step();
    check("rst_blocks_transfer", d0_sym_ready, 1);
    rst       = 1'b0;
    sym_valid = 1'b0;
    step();
    step();
    check("discarded_busy", d0_busy, 0);
    check("discarded_start", d0_sym_start, 0);
    check("discarded_d1_busy", d1_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
